// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus arbiter slice.
package cdb_pkg;

   localparam int CDB_WIDTH   = 31;  // MSB index of result data
   localparam int CDB_T_WIDTH = 3;   // MSB index of ROB tag
   localparam int CDB_N_FU    = 4;   // number of functional units

   // Functional-unit slot assignment on the arbiter inputs.
   localparam int FU_ALU    = 0;
   localparam int FU_BRANCH = 1;
   localparam int FU_MEM    = 2;
   localparam int FU_MUL    = 3;

   // One broadcast as seen by the reservation stations, ROB and register status.
   typedef struct packed {
      logic                   valid;
      logic [CDB_T_WIDTH:0]   tag;
      logic [CDB_WIDTH:0]     data;
   } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-request side and broadcast side of the common data bus.
interface cdb_arbiter_if
   import cdb_pkg::*;
#(
   parameter int N_FU    = CDB_N_FU,
   parameter int WIDTH   = CDB_WIDTH,
   parameter int T_WIDTH = CDB_T_WIDTH
);
   localparam int SRC_W = $clog2(N_FU);

   logic [N_FU-1:0]             fu_req;
   logic [N_FU*(WIDTH+1)-1:0]   fu_data;
   logic [N_FU*(T_WIDTH+1)-1:0] fu_tag;
   logic [N_FU-1:0]             fu_ready;
   logic                        cdb_valid;
   logic [WIDTH:0]              cdb_data;
   logic [T_WIDTH:0]            cdb_tag;
   logic [SRC_W-1:0]            cdb_src;

   // Functional units and CDB consumers.
   modport master (
      output fu_req, fu_data, fu_tag,
      input  fu_ready, cdb_valid, cdb_data, cdb_tag, cdb_src
   );

   // The arbiter.
   modport slave (
      input  fu_req, fu_data, fu_tag,
      output fu_ready, cdb_valid, cdb_data, cdb_tag, cdb_src
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so that last+1 sits at
// position 0, priority-encode the lowest set bit, rotate the index back.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx
);
   localparam int IW = $clog2(N);

   logic [N-1:0]  rot;
   logic [IW-1:0] src;
   logic [IW-1:0] enc;
   logic          found;

   // Rotate, encode and map back to the unit index.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write so no latch is inferred.
      rot       = '0;
      src       = '0;
      enc       = '0;
      found     = 1'b0;
      grant     = '0;
      grant_idx = '0;
      for (int k = 0; k < N; k++) begin
         src    = IW'((int'(last) + 1 + k) % N);
         rot[k] = req[src];
      end
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            enc   = IW'(k);
            found = 1'b1;
         end
      end
      if (found) begin
         grant_idx        = IW'((int'(last) + 1 + int'(enc)) % N);
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per functional unit, a
// round-robin pick among occupied buffers, and a registered CDB broadcast.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int WIDTH   = CDB_WIDTH,
   parameter int T_WIDTH = CDB_T_WIDTH,
   parameter int N_FU    = CDB_N_FU
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   cdb_arbiter_if.slave bus
);
   localparam int SRC_W = $clog2(N_FU);

   typedef struct packed {
      logic [T_WIDTH:0] tag;
      logic [WIDTH:0]   data;
   } entry_t;

   logic [N_FU-1:0]  buf_valid;
   entry_t           buf_entry [N_FU];
   logic [SRC_W-1:0] last;

   logic [N_FU-1:0]  arb_req;
   logic [N_FU-1:0]  grant;
   logic [SRC_W-1:0] grant_idx;
   logic             any_grant;
   logic [N_FU-1:0]  ready;

   logic             cdb_valid_q;
   logic [WIDTH:0]   cdb_data_q;
   logic [T_WIDTH:0] cdb_tag_q;
   logic [SRC_W-1:0] cdb_src_q;

   // A flush suppresses arbitration so nothing about to be discarded is broadcast.
   assign arb_req = flush ? '0 : buf_valid;

   rr_arbiter #(.N(N_FU)) u_rr (
      .req       (arb_req),
      .last      (last),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign any_grant = |grant;

   // Ready looks only at buffer state and grant, never at fu_req.
   assign ready        = flush ? '1 : (~buf_valid | grant);
   assign bus.fu_ready = ready;

   // Buffer occupancy: set on accept, cleared on a grant with no new result.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      if (reset || flush) begin
         buf_valid <= '0;
      end else begin
         for (int i = 0; i < N_FU; i++) begin
            if (bus.fu_req[i] && ready[i]) begin
               buf_valid[i] <= 1'b1;
            end else if (grant[i]) begin
               buf_valid[i] <= 1'b0;
            end
         end
      end
   end

   // Buffer payload: load the unit's result whenever it is accepted.
   always_ff @(posedge clk) begin
      // NOTE: payload storage has no reset; buf_valid alone decides whether it means anything.
      for (int i = 0; i < N_FU; i++) begin
         if (!flush && bus.fu_req[i] && ready[i]) begin
            buf_entry[i] <= '{tag:  bus.fu_tag[i*(T_WIDTH+1) +: T_WIDTH+1],
                              data: bus.fu_data[i*(WIDTH+1) +: WIDTH+1]};
         end
      end
   end

   // Round-robin pointer and registered CDB broadcast.
   always_ff @(posedge clk) begin
      if (reset) begin
         last        <= SRC_W'(N_FU - 1);
         cdb_valid_q <= 1'b0;
         cdb_data_q  <= '0;
         cdb_tag_q   <= '0;
         cdb_src_q   <= '0;
      end else if (any_grant) begin
         last        <= grant_idx;
         cdb_valid_q <= 1'b1;
         cdb_data_q  <= buf_entry[grant_idx].data;
         cdb_tag_q   <= buf_entry[grant_idx].tag;
         cdb_src_q   <= grant_idx;
      end else begin
         cdb_valid_q <= 1'b0;
      end
   end

   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_data  = cdb_data_q;
   assign bus.cdb_tag   = cdb_tag_q;
   assign bus.cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized
// run, all compared against a behavioural model of buffers and rotation.
module tb_cdb_arbiter;
   import cdb_pkg::*;

   localparam int N  = 4;
   localparam int W  = 31;
   localparam int TW = 3;

   logic clk = 1'b0;
   logic reset;
   logic flush;

   always #5 clk = ~clk;

   cdb_arbiter_if #(.N_FU(N), .WIDTH(W), .T_WIDTH(TW)) bus ();

   cdb_arbiter #(.WIDTH(W), .T_WIDTH(TW), .N_FU(N)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Values each unit presents when it requests.
   logic [W:0]  drv_data [N];
   logic [TW:0] drv_tag  [N];

   // Behavioural model: occupied buffers, last granted unit, expected CDB.
   bit          m_valid [N];
   logic [W:0]  m_data  [N];
   logic [TW:0] m_tag   [N];
   int          m_last;
   cdb_packet_t exp_cdb;
   logic [1:0]  exp_src;
   logic [N-1:0] exp_ready;
   logic [N-1:0] obs_ready;

   // One clock cycle: drive at negedge, sample ready, advance model, land #1 after posedge.
   task automatic step(input logic [N-1:0] req, input logic fl);
      int g;
      @(negedge clk);
      bus.fu_req = req;
      flush      = fl;
      for (int i = 0; i < N; i++) begin
         bus.fu_data[i*(W+1) +: W+1]   = drv_data[i];
         bus.fu_tag[i*(TW+1) +: TW+1]  = drv_tag[i];
      end
      #1;
      g = -1;
      if (!fl) begin
         for (int k = 1; k <= N; k++) begin
            int u;
            u = (m_last + k) % N;
            if (g < 0 && m_valid[u]) g = u;
         end
      end
      for (int i = 0; i < N; i++) exp_ready[i] = fl || !m_valid[i] || (g == i);
      obs_ready = bus.fu_ready;
      if (fl) begin
         for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
         exp_cdb.valid = 1'b0;
      end else begin
         if (g >= 0) begin
            exp_cdb = '{valid: 1'b1, tag: m_tag[g], data: m_data[g]};
            exp_src = 2'(g);
            m_last  = g;
         end else begin
            exp_cdb.valid = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (req[i] && exp_ready[i]) begin
               m_valid[i] = 1'b1;
               m_data[i]  = drv_data[i];
               m_tag[i]   = drv_tag[i];
            end else if (g == i) begin
               m_valid[i] = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // One reset cycle, optionally with flush and requests active at the same time.
   task automatic do_reset(input logic fl);
      @(negedge clk);
      reset      = 1'b1;
      flush      = fl;
      bus.fu_req = 4'($urandom);
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0;
      end
      m_last    = N - 1;
      exp_cdb   = '0;
      exp_src   = '0;
      exp_ready = '1;
      @(posedge clk);
      #1;
      reset      = 1'b0;
      flush      = 1'b0;
      bus.fu_req = '0;
      obs_ready  = bus.fu_ready;
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      checks++;
      if ({bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_src} !== 39'd0) begin
         errors++;
         $display("FAIL reset_cdb: got v=%b d=%h t=%h s=%0d, expected all zero",
                  bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_src);
      end
      checks++;
      if (bus.fu_ready !== 4'b1111) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 1111", bus.fu_ready);
      end
   endtask

   task automatic test_single();
      do_reset(1'b0);
      drv_data[FU_ALU] = 32'h0000_00AA;
      drv_tag[FU_ALU]  = 4'd5;
      step(4'b0001, 1'b0);
      checks++;
      if (obs_ready[FU_ALU] !== 1'b1) begin
         errors++;
         $display("FAIL single_ready: got %b expected 1", obs_ready[FU_ALU]);
      end
      checks++;
      if (bus.cdb_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_t1: cdb_valid got %b expected 0", bus.cdb_valid);
      end
      step(4'b0000, 1'b0);
      checks++;
      if ({bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_src} !== {1'b1, 32'h0000_00AA, 4'd5, 2'd0}) begin
         errors++;
         $display("FAIL single_t2: got v=%b d=%h t=%0d s=%0d expected v=1 d=000000aa t=5 s=0",
                  bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_src);
      end
      step(4'b0000, 1'b0);
      checks++;
      if (bus.cdb_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_t3: cdb_valid got %b expected 0", bus.cdb_valid);
      end
   endtask

   task automatic test_all_four();
      do_reset(1'b0);
      for (int i = 0; i < N; i++) begin
         drv_data[i] = 32'hA000_0000 + 32'(i);
         drv_tag[i]  = 4'(8 + i);
      end
      step(4'b1111, 1'b0);
      for (int c = 0; c < 5; c++) begin
         step(4'b0000, 1'b0);
         checks++;
         if (c < 4 && (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'(c) ||
                       bus.cdb_data !== 32'hA000_0000 + 32'(c))) begin
            errors++;
            $display("FAIL all_four broadcast %0d: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                     c, bus.cdb_valid, bus.cdb_src, bus.cdb_data, c, 32'hA000_0000 + 32'(c));
         end else if (c == 4 && bus.cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL all_four tail: cdb_valid got %b expected 0", bus.cdb_valid);
         end
      end
   endtask

   task automatic test_streaming();
      int srcs[$];
      int low_run;
      int max_low;
      do_reset(1'b0);
      low_run = 0;
      max_low = 0;
      drv_data[FU_BRANCH] = 32'hB0B0_0001;
      drv_tag[FU_BRANCH]  = 4'd1;
      drv_data[FU_MEM]    = 32'hC0C0_0002;
      drv_tag[FU_MEM]     = 4'd2;
      for (int c = 0; c < 12; c++) begin
         drv_data[FU_ALU] = 32'h1000_0000 + 32'(c);
         drv_tag[FU_ALU]  = 4'(c);
         step((c == 0) ? 4'b0111 : 4'b0001, 1'b0);
         if (!obs_ready[FU_ALU]) low_run++;
         else low_run = 0;
         if (low_run > max_low) max_low = low_run;
         if (bus.cdb_valid === 1'b1) srcs.push_back(int'(bus.cdb_src));
         checks++;
         if (obs_ready !== exp_ready || bus.cdb_valid !== exp_cdb.valid || bus.cdb_data !== exp_cdb.data ||
             bus.cdb_tag !== exp_cdb.tag || bus.cdb_src !== exp_src) begin
            errors++;
            $display("FAIL streaming cycle %0d: got rdy=%b v=%b d=%h t=%h s=%0d expected rdy=%b v=%b d=%h t=%h s=%0d",
                     c, obs_ready, bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_src,
                     exp_ready, exp_cdb.valid, exp_cdb.data, exp_cdb.tag, exp_src);
         end
      end
      checks++;
      if (srcs.size() < 4 || srcs[0] != 0 || srcs[1] != 1 || srcs[2] != 2 || srcs[3] != 0) begin
         errors++;
         $display("FAIL streaming_order: got %p expected first four 0 1 2 0", srcs);
      end
      checks++;
      if (max_low > N - 1) begin
         errors++;
         $display("FAIL streaming_ready_low: got run %0d expected at most %0d", max_low, N - 1);
      end
   endtask

   task automatic test_back_pressure();
      do_reset(1'b0);
      drv_data[FU_BRANCH] = 32'h0000_0111;
      drv_tag[FU_BRANCH]  = 4'd1;
      drv_data[FU_MEM]    = 32'h0000_0222;
      drv_tag[FU_MEM]     = 4'd2;
      step(4'b0110, 1'b0);
      drv_data[FU_MEM] = 32'h0000_02BB;
      drv_tag[FU_MEM]  = 4'd6;
      step(4'b0100, 1'b0);
      checks++;
      if (obs_ready[FU_MEM] !== 1'b0) begin
         errors++;
         $display("FAIL bp_ready: fu_ready[2] got %b expected 0", obs_ready[FU_MEM]);
      end
      step(4'b0100, 1'b0);
      checks++;
      if ({bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_src} !== {1'b1, 32'h0000_0222, 4'd2, 2'd2}) begin
         errors++;
         $display("FAIL bp_first: got v=%b d=%h t=%0d s=%0d expected v=1 d=00000222 t=2 s=2",
                  bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_src);
      end
      step(4'b0000, 1'b0);
      checks++;
      if ({bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_src} !== {1'b1, 32'h0000_02BB, 4'd6, 2'd2}) begin
         errors++;
         $display("FAIL bp_held: got v=%b d=%h t=%0d s=%0d expected v=1 d=000002bb t=6 s=2",
                  bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_src);
      end
   endtask

   task automatic test_flush();
      int leaked;
      do_reset(1'b0);
      leaked = 0;
      for (int i = 0; i < N; i++) begin
         drv_data[i] = 32'hF000_0000 + 32'(i);
         drv_tag[i]  = 4'(12 + i);
      end
      step(4'b0111, 1'b0);
      step(4'b1000, 1'b1);
      checks++;
      if (obs_ready !== 4'b1111) begin
         errors++;
         $display("FAIL flush_ready_during: got %b expected 1111", obs_ready);
      end
      checks++;
      if (bus.cdb_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_cdb: cdb_valid got %b expected 0", bus.cdb_valid);
      end
      for (int c = 0; c < 6; c++) begin
         step(4'b0000, 1'b0);
         if (c == 0) begin
            checks++;
            if (obs_ready !== 4'b1111) begin
               errors++;
               $display("FAIL flush_ready_after: got %b expected 1111", obs_ready);
            end
         end
         if (bus.cdb_valid === 1'b1 && bus.cdb_tag >= 4'd12) leaked++;
      end
      checks++;
      if (leaked != 0) begin
         errors++;
         $display("FAIL flush_leak: got %0d flushed broadcasts expected 0", leaked);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b0);
      for (int i = 0; i < N; i++) begin
         drv_data[i] = 32'h5500_0000 + 32'(i);
         drv_tag[i]  = 4'(1 + i);
      end
      step(4'b1111, 1'b0);
      step(4'b0000, 1'b0);
      checks++;
      if (bus.cdb_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_pre: cdb_valid got %b expected 1", bus.cdb_valid);
      end
      do_reset(1'b1);
      checks++;
      if ({bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_src} !== 39'd0 || obs_ready !== 4'b1111) begin
         errors++;
         $display("FAIL reset_mid_values: got v=%b d=%h t=%h s=%0d rdy=%b expected zeros and 1111",
                  bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_src, obs_ready);
      end
      step(4'b0101, 1'b0);
      step(4'b0000, 1'b0);
      checks++;
      if (bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd0) begin
         errors++;
         $display("FAIL reset_mid_first_grant: got v=%b s=%0d expected v=1 s=0",
                  bus.cdb_valid, bus.cdb_src);
      end
   endtask

   task automatic test_random();
      do_reset(1'b0);
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 63) == 0) begin
            do_reset($urandom_range(0, 1) == 1);
         end else begin
            for (int i = 0; i < N; i++) begin
               drv_data[i] = $urandom;
               drv_tag[i]  = 4'($urandom_range(0, 15));
            end
            step(4'($urandom), $urandom_range(0, 15) == 0);
         end
         checks++;
         if (obs_ready !== exp_ready || bus.cdb_valid !== exp_cdb.valid || bus.cdb_data !== exp_cdb.data ||
             bus.cdb_tag !== exp_cdb.tag || bus.cdb_src !== exp_src) begin
            errors++;
            $display("FAIL random cycle %0d: got rdy=%b v=%b d=%h t=%h s=%0d expected rdy=%b v=%b d=%h t=%h s=%0d",
                     c, obs_ready, bus.cdb_valid, bus.cdb_data, bus.cdb_tag, bus.cdb_src,
                     exp_ready, exp_cdb.valid, exp_cdb.data, exp_cdb.tag, exp_src);
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      flush       = 1'b0;
      bus.fu_req  = '0;
      bus.fu_data = '0;
      bus.fu_tag  = '0;
      for (int i = 0; i < N; i++) begin
         drv_data[i] = '0;
         drv_tag[i]  = '0;
      end
      test_reset();
      test_single();
      test_all_four();
      test_streaming();
      test_back_pressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
